// File: rtl/mem_responder_if.sv
// CPU-to-memory bus: read/write strobes, byte address and write data toward the
// responder; read data, completion pulse, fault flag and LED register back.
interface mem_responder_if;
  logic        Memread;
  logic        Memwrite;
  logic [31:0] Addr;
  logic [31:0] Memout;
  logic [31:0] Memin;
  logic        Ready;
  logic        Fault;
  logic [31:0] Ledout;

  modport master (
    output Memread, Memwrite, Addr, Memout,
    input  Memin, Ready, Fault, Ledout
  );

  modport slave (
    input  Memread, Memwrite, Addr, Memout,
    output Memin, Ready, Fault, Ledout
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM responder with configurable wait states and a sticky fault flag.
// Define MEM_MMIO_EN to enable the 0xF region (LED register, tick counter, status).
module mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned WAIT       = 0
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [2:0] {REG_RAM, REG_LED, REG_TICK, REG_STAT, REG_OOR} region_t;

  localparam int unsigned WORDS = 1 << ADDR_WIDTH;

  logic [31:0] mem [WORDS];

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [31:0] lat_addr;
  logic        lat_rd;
  logic [31:0] memin_q;
  logic        ready_q;
  logic        fault_q;

  logic        strobe, accept, acc_wr, acc_rd;
  logic        respond, resp_rd, fault_set, fault_clr;
  logic [31:0] resp_addr, rd_val;
  region_t     acc_region, resp_region;

`ifdef MEM_MMIO_EN
  logic [31:0] led_q;
  logic [31:0] tick_q;
`endif

  function automatic region_t decode(input logic [31:0] a);
    region_t r;
    r = REG_OOR;
    if (a[31:28] == 4'h0 && (a[27:0] >> (ADDR_WIDTH + 2)) == 28'd0) r = REG_RAM;
`ifdef MEM_MMIO_EN
    else if (a[31:28] == 4'hF) begin
      case ({a[27:2], 2'b00})
        28'h000_0000: r = REG_LED;
        28'h000_0004: r = REG_TICK;
        28'h000_0008: r = REG_STAT;
        default:      r = REG_OOR;
      endcase
    end
`endif
    return r;
  endfunction

  assign strobe      = bus.Memread | bus.Memwrite;
  assign accept      = (state == IDLE) && strobe;
  assign acc_wr      = accept && bus.Memwrite;
  assign acc_rd      = accept && bus.Memread && !bus.Memwrite;
  assign acc_region  = decode(bus.Addr);

  // With WAIT=0 the response is formed from the live bus on the acceptance edge.
  assign resp_addr   = (state == IDLE) ? bus.Addr : lat_addr;
  assign resp_rd     = (state == IDLE) ? acc_rd : lat_rd;
  assign resp_region = decode(resp_addr);
  assign respond     = (state == RESP) || (accept && WAIT == 0);

  assign fault_set = (accept && (bus.Addr[1:0] != 2'b00 || (bus.Memread && bus.Memwrite) ||
                                 acc_region == REG_OOR))
                   || (state != IDLE && strobe);
`ifdef MEM_MMIO_EN
  assign fault_clr = acc_wr && acc_region == REG_STAT;
`else
  assign fault_clr = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (resp_region)
      REG_RAM:  rd_val = mem[resp_addr[ADDR_WIDTH+1:2]];
`ifdef MEM_MMIO_EN
      REG_LED:  rd_val = led_q;
      REG_TICK: rd_val = tick_q;
      REG_STAT: rd_val = {31'b0, fault_q};
`endif
      default:  rd_val = '0;
    endcase
  end

  // RESP is the last waiting cycle; the response registers on the edge leaving it,
  // so a strobe accepted at edge N completes at N+WAIT and the next lands at N+WAIT+1.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept && WAIT != 0) begin
          if (WAIT == 1) begin
            state_next = RESP;
          end else begin
            state_next = BUSY;
            cnt_next   = 4'(WAIT - 1);
          end
        end
      end
      BUSY: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && acc_wr && acc_region == REG_RAM)
      mem[bus.Addr[ADDR_WIDTH+1:2]] <= bus.Memout;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_addr <= '0;
      lat_rd   <= 1'b0;
      memin_q  <= '0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
`ifdef MEM_MMIO_EN
      led_q    <= '0;
      tick_q   <= '0;
`endif
    end else begin
      if (accept) begin
        lat_addr <= bus.Addr;
        lat_rd   <= acc_rd;
      end
      ready_q <= respond;
      if (respond && resp_rd) memin_q <= rd_val;
      if (fault_clr)      fault_q <= 1'b0;
      else if (fault_set) fault_q <= 1'b1;
`ifdef MEM_MMIO_EN
      tick_q <= tick_q + 32'd1;
      if (acc_wr && acc_region == REG_LED) led_q <= bus.Memout;
`endif
    end
  end

  assign bus.Memin  = memin_q;
  assign bus.Ready  = ready_q;
  assign bus.Fault  = fault_q;
`ifdef MEM_MMIO_EN
  assign bus.Ledout = led_q;
`else
  assign bus.Ledout = '0;
`endif

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle CPU's memory bus: accepts `Memread`/`Memwrite` strobes with `Addr` and `Memout`, and returns read data on `Memin`. It contains a word-addressed RAM for instructions and data, optional memory-mapped I/O, and a configurable wait-state engine. A one-cycle `Ready` pulse and a sticky `Fault` flag allow a future stalling CPU. It sits directly between the CPU's memory port and the board top level.

## Interface

Parameters
- `ADDR_WIDTH`, default 10: RAM word-index bits; 2^ADDR_WIDTH words of 32 bits.
- `WAIT`, default 0: extra wait cycles before a response, range 0–15.

Ports
- `clk`  in  1: the single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `Memread`  in  1: read strobe, sampled at the rising edge.
- `Memwrite`  in  1: write strobe, sampled at the rising edge.
- `Addr`  in  32: byte address.
- `Memout`  in  32: write data from the CPU.
- `Memin`  out  32: registered read data.
- `Ready`  out  1: one-cycle pulse when an access completes.
- `Fault`  out  1: sticky error flag.
- `Ledout`  out  32: MMIO LED register.

## Operation

- **Reset** (edge with `rst`=0):
  - `Memin`=0, `Ready`=0, `Fault`=0, `Ledout`=0.
  - Tick counter=0, FSM goes to IDLE.
  - RAM contents are not cleared.
- **FSM states:** IDLE, BUSY, RESP.
  - IDLE: a strobe is accepted. `Addr`, `Memout` and the read/write kind are latched, and a wait counter is loaded with `WAIT`.
    - If `WAIT`=0, the FSM goes straight to RESP behaviour on the same edge. Otherwise it goes to BUSY.
  - BUSY: the counter decrements each cycle. At 0 the FSM goes to RESP.
  - RESP: read data is registered into `Memin` and `Ready`=1 for exactly one cycle. The FSM then returns to IDLE.
- **Writes:** committed at the acceptance edge from the latched data. `Memin` is unchanged by a write, and `Ready` still pulses.
- **Address decode** (uses the latched address):
  - `Addr[31:28]`=0 selects RAM at word index `Addr[ADDR_WIDTH+1:2]`.
  - Any nonzero bit in `Addr[27:ADDR_WIDTH+2]` is out of range:
    - a read returns 0;
    - a write is dropped;
    - `Fault` is set.
  - `Addr[31:28]`=0xF selects MMIO (see Configuration).
  - Every other region behaves as out of range.
- **Misaligned access** (`Addr[1:0]`≠0): the access proceeds with the low bits ignored, and `Fault` is set.
- **Simultaneous strobes** (`Memread` and `Memwrite` both high):
  - the write is performed;
  - `Memin` is held;
  - `Fault` is set.
- **Strobes during BUSY or RESP:** ignored, and `Fault` is set.
- **`Fault` persistence:** once set, it stays set until reset or an MMIO clear.
- **Tick counter:** 32 bits, increments every cycle out of reset, and wraps from 0xFFFFFFFF to 0.

## Timing

- `WAIT`=0:
  - a strobe sampled at edge N gives `Memin` valid and `Ready`=1 from edge N to edge N+1;
  - back-to-back strobes are accepted every cycle.
  - This matches the CPU, which sets `Addr` and samples `Memin` in the following stage.
- `WAIT`=W>0:
  - the strobe is accepted at edge N;
  - `Memin` and `Ready` update at edge N+W;
  - the next acceptance can happen at edge N+W+1.
- Read-after-write to the same word on the next accepted access returns the new data.
- Reset asserted mid-access:
  - the FSM goes to IDLE and `Ready` drops;
  - a write already accepted stays committed;
  - a pending read response is discarded.

## Configuration

- **`MEM_MMIO_EN` defined:** the 0xF region decodes as follows.
  - 0xF0000000: `Ledout`, read/write.
  - 0xF0000004: tick counter, read-only. Writes are ignored without a fault.
  - 0xF0000008: status register. A read returns {31'b0,`Fault`}. A write of any value clears `Fault`; that write edge does not set it again.
  - Other 0xF addresses are out of range.
- **`MEM_MMIO_EN` not defined:**
  - the whole 0xF region is out of range;
  - `Ledout` is tied to 0;
  - there is no tick counter;
  - `Fault` clears only on reset.

## Test plan

- **Basic write then read (`WAIT`=0):**
  - Stimulus: write 0xDEADBEEF to 0x00000010, then read 0x00000010 on the next cycle.
  - Required: `Memin`=0xDEADBEEF one cycle after the read strobe, `Ready` pulses once per access, and `Fault`=0.
- **Wait states (`WAIT`=3):**
  - Stimulus: read 0x00000010.
  - Required: `Memin` updates and `Ready`=1 exactly 3 edges after acceptance. A `Memread` asserted during BUSY is ignored and sets `Fault`=1.
- **Out of range (`ADDR_WIDTH`=10):**
  - Stimulus: write 0x12345678 to 0x00001000, then read 0x00001000.
  - Required: the write is dropped, the read returns 0, `Fault`=1, and word 0 still holds its prior value.
- **Misaligned and simultaneous strobes:**
  - Stimulus: read 0x00000012, then assert both strobes at 0x00000014 with 0xA5A5A5A5.
  - Required: the first read returns word 4's data with `Fault`=1. Word 5 becomes 0xA5A5A5A5 and `Memin` is unchanged.
- **MMIO (`MEM_MMIO_EN` defined):**
  - Stimulus: write 0x0000_00FF to 0xF0000000, read 0xF0000004 twice 5 cycles apart, then write 0xF0000008.
  - Required: `Ledout`=0xFF, the two counter reads differ by 5, and `Fault` returns to 0.
- **Reset mid-access (`WAIT`=4):**
  - Stimulus: pull `rst` low 2 cycles after a write of 0x0000CAFE to 0x00000020 is accepted.
  - Required: `Ready` never pulses. After reset, a read of 0x00000020 returns 0x0000CAFE, and `Memin` and `Ledout` read 0 right after reset.
